alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Multi-precision add/subtract sequencer built around a single 4-bit add/sub slice. It accepts NIBBLES*4-bit operands and runs the slice once per cycle, LSB nibble first, chaining carry/borrow between nibbles. It returns a wide result with zero and carry flags. It sits between the datapath control logic and the narrow ALU, trading latency for area.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation (>=1); operand width W = 4*NIBBLES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
op  input  1  1 = add (A+B+cin), 0 = subtract (A-B-cin)
cin  input  1  initial carry-in/borrow-in for nibble 0
a  input  W  operand A, sampled on accepting edge
b  input  W  operand B, sampled on accepting edge
ready  output  1  high in IDLE only
done  output  1  one-cycle pulse; result/flags valid
result  output  W  sum/difference, held until next accepted start
zf  output  1  1 when result == 0
cf  output  1  add: final carry-out; sub: inverse of final borrow (1 = no borrow)
ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- States: IDLE, RUN, DONE. The state register, idx counter (clog2(NIBBLES) bits, min 1), carry register, operand registers and result register are all cleared asynchronously when rst_n=0.
- Reset values: ready=1 (IDLE), done=0, result=0, zf=0, cf=0, ovf=0.
- IDLE: start=1 on an edge latches a, b, op. Carry register <= cin, idx <= 0, result <= 0, zf/cf/ovf <= 0, then go to RUN. With start=0, stay in IDLE.
- RUN, each edge:
  - The slice sees A=a_reg[idx*4+:4], B=b_reg[idx*4+:4], C0=carry_reg, Add_Sub=op.
  - result[idx*4+:4] <= F, and carry_reg <= C4. C4 is the 5th bit of the 5-bit slice result: carry for add, borrow for subtract.
  - If idx==NIBBLES-1: go to DONE and register flags. zf = (final result==0), computed from the completed word including the current F. cf = op ? C4 : ~C4.
  - Otherwise idx <= idx+1.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE. start is ignored in DONE.
- Latency: done is high during the cycle following the NIBBLES-th edge after the accepting edge. Throughput is one operation per NIBBLES+2 cycles.
- start while ready=0: ignored, not queued.
- a, b, op and cin changing during RUN have no effect (registered copies are used).
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; the in-flight operation is lost.
- NIBBLES=1: RUN lasts one edge; result equals a single slice operation.
- Arithmetic: wrap-around modulo 2^W; no saturation.

Optional Feature:
- Macro ALU_SEQ_OVF_EN.
- When defined: on the final RUN edge, ovf <= signed overflow using MSBs of a_reg, b_reg and the final result.
  - Add: (a_msb==b_msb) && (r_msb!=a_msb).
  - Sub: (a_msb!=b_msb) && (r_msb!=a_msb).
- When not defined: the ovf port is still present and tied to 0, and no overflow logic is generated.

Decomposition:
- Package alu_seq_pkg holds:
  - state typedef (IDLE, RUN, DONE)
  - constants OP_ADD=1'b1, OP_SUB=1'b0, NIB_W=4
- One sub-module, nibble_addsub: combinational 4-bit add/sub slice with ports C0, Add_Sub, A[3:0], B[3:0], F[3:0], C4. It is instantiated once. The wide ZF/CF flags are produced by the controller, not the slice.

Test Plan:
- NIBBLES=4, add 0x1234+0x0FCD, cin=0 -> result 0x2201, zf=0, cf=0. done pulses one cycle during the 5th cycle after the accepting edge; ready low in between.
- Add 0xFFFF+0x0001, cin=0 -> result 0x0000, zf=1, cf=1.
- Sub 0x1000-0x0001, cin=0 -> 0x0FFF, cf=1, zf=0. Sub 0x0000-0x0001 -> 0xFFFF, cf=0. Sub 0x0005-0x0004 with cin=1 -> 0x0000, zf=1, cf=1.
- start held high continuously with changing a/b during RUN -> only the first operands are used. Next accept occurs on the first IDLE edge after done, with no extra accept during RUN/DONE.
- Pull rst_n low during the 2nd RUN cycle -> ready=1, done=0, result=0 immediately. A subsequent add 0x0001+0x0001 returns 0x0002 correctly.
- Macro ALU_SEQ_OVF_EN defined:
  - add 0x7FFF+0x0001 -> 0x8000, ovf=1
  - sub 0x8000-0x0001 -> 0x7FFF, ovf=1
  - add 0x0001+0x0001 -> ovf=0
  - Macro undefined: ovf stays 0 in all cases.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared states and constants for the nibble-serial add/sub sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;
  localparam int NIB_W = 4;
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: request/result bundle between datapath control and the sequencer
interface alu_seq_ctrl_if import alu_seq_pkg::*; #(parameter int NIBBLES = 4);
  localparam int W = NIBBLES * NIB_W;
  logic start;
  logic op;
  logic cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic ready;
  logic done;
  logic [W-1:0] result;
  logic zf;
  logic cf;
  logic ovf;
  modport master(output start, op, cin, a, b, input ready, done, result, zf, cf, ovf);
  modport slave(input start, op, cin, a, b, output ready, done, result, zf, cf, ovf);
endinterface

// File: rtl/nibble_addsub.sv
// nibble_addsub: 4-bit add/sub slice; C4 is carry for add, borrow for subtract
module nibble_addsub import alu_seq_pkg::*; (
  input  logic       C0,
  input  logic       Add_Sub,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] F,
  output logic       C4
);
  assign {C4, F} = Add_Sub == OP_ADD ? {1'b0, A} + {1'b0, B} + {4'b0, C0}
                                     : {1'b0, A} - {1'b0, B} - {4'b0, C0};
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-precision add/sub run one nibble per cycle, LSB first
// Define ALU_SEQ_OVF_EN to generate signed-overflow logic; otherwise ovf is tied low.
module alu_seq_ctrl import alu_seq_pkg::*; #(parameter int NIBBLES = 4) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_ctrl_if.slave bus
);
  localparam int W = NIBBLES * NIB_W;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic carry, op_r, zf_r, cf_r, c4, last, accept;
  logic [W-1:0] a_r, b_r, res, res_nx;
  logic [NIB_W-1:0] f;
  assign last = idx == IW'(NIBBLES - 1);
  assign accept = state == IDLE && bus.start;
  nibble_addsub u_slice (
    .C0(carry),
    .Add_Sub(op_r),
    .A(a_r[idx*NIB_W +: NIB_W]),
    .B(b_r[idx*NIB_W +: NIB_W]),
    .F(f),
    .C4(c4)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (bus.start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
    res_nx = res;
    res_nx[idx*NIB_W +: NIB_W] = f;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      op_r <= 1'b0;
      carry <= 1'b0;
      idx <= '0;
      res <= '0;
      zf_r <= 1'b0;
      cf_r <= 1'b0;
    end else if (accept) begin
      a_r <= bus.a;
      b_r <= bus.b;
      op_r <= bus.op;
      carry <= bus.cin;
      idx <= '0;
      res <= '0;
      zf_r <= 1'b0;
      cf_r <= 1'b0;
    end else if (state == RUN) begin
      res <= res_nx;
      carry <= c4;
      if (last) begin
        zf_r <= res_nx == '0;
        cf_r <= op_r == OP_ADD ? c4 : ~c4;
      end else idx <= idx + 1'b1;
    end
`ifdef ALU_SEQ_OVF_EN
  logic ovf_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_r <= 1'b0;
    else if (accept) ovf_r <= 1'b0;
    else if (state == RUN && last)
      ovf_r <= res_nx[W-1] != a_r[W-1] &&
               (op_r == OP_ADD ? a_r[W-1] == b_r[W-1] : a_r[W-1] != b_r[W-1]);
  assign bus.ovf = ovf_r;
`else
  assign bus.ovf = 1'b0;
`endif
  assign bus.ready = state == IDLE;
  assign bus.done = state == DONE;
  assign bus.result = res;
  assign bus.zf = zf_r;
  assign bus.cf = cf_r;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: randomized bench with a whole-word arithmetic model and cycle-count timing
module tb_alu_seq_ctrl;
  localparam int NIB = 4;
  localparam int W = NIB * 4;
`ifdef ALU_SEQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  alu_seq_ctrl_if #(.NIBBLES(NIB)) bus ();
  alu_seq_ctrl #(.NIBBLES(NIB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [W+2:0] ref_op(input logic o, c, input logic [W-1:0] x, y);
    logic [W:0] s;
    logic [W-1:0] r;
    logic ov;
    s = o ? {1'b0, x} + {1'b0, y} + (W+1)'(c) : {1'b0, x} - {1'b0, y} - (W+1)'(c);
    r = s[W-1:0];
    ov = (r[W-1] != x[W-1]) && (o ? x[W-1] == y[W-1] : x[W-1] != y[W-1]);
    return {ov, o ? s[W] : ~s[W], r == '0, r};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted op occupies NIB+2 edges; done shows after the NIB-th edge past the accept
  bit active = 1'b0;
  int cyc = 0;
  int acc = 0;
  logic [W-1:0] e_r = '0;
  bit e_z = 1'b0, e_c = 1'b0, e_o = 1'b0;
  logic m_ready, m_done;
  assign m_ready = !active || (cyc - acc >= NIB + 1);
  assign m_done = active && (cyc - acc == NIB);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      active <= 1'b0;
      cyc <= 0;
      acc <= 0;
      e_r <= '0;
      e_z <= 1'b0;
      e_c <= 1'b0;
      e_o <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (m_ready && bus.start) begin
        acc <= cyc + 1;
        active <= 1'b1;
        {e_o, e_c, e_z, e_r} <= ref_op(bus.op, bus.cin, bus.a, bus.b);
      end
    end

  always @(negedge clk) begin
    chk("ready", 32'(bus.ready), 32'(m_ready));
    chk("done", 32'(bus.done), 32'(m_done));
    if (m_ready || m_done) begin
      chk("result", 32'(bus.result), 32'(e_r));
      chk("zf", 32'(bus.zf), 32'(e_z));
      chk("cf", 32'(bus.cf), 32'(e_c));
      chk("ovf", 32'(bus.ovf), 32'(e_o & OVF_EN));
    end
  end

  task automatic run_op(input logic o, c, input logic [W-1:0] x, y, er, input logic ez, ec, eo, input string nm);
    int n;
    n = 0;
    while (!bus.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_rdy"}, 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.op = o;
    bus.cin = c;
    bus.a = x;
    bus.b = y;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      bus.op = 1'($urandom);
      bus.cin = 1'($urandom);
      bus.a = W'($urandom);
      bus.b = W'($urandom);
    end while (!bus.done && n < 40);
    chk({nm, "_lat"}, 32'(n), 32'(NIB + 1));
    chk({nm, "_res"}, 32'(bus.result), 32'(er));
    chk({nm, "_zf"}, 32'(bus.zf), 32'(ez));
    chk({nm, "_cf"}, 32'(bus.cf), 32'(ec));
    chk({nm, "_ovf"}, 32'(bus.ovf), 32'(eo & OVF_EN));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.cin = 1'b0;
    bus.a = '0;
    bus.b = '0;
    chk("pin_add", 32'(ref_op(1'b1, 1'b0, 16'h1234, 16'h0FCD)), 32'({1'b0, 1'b0, 1'b0, 16'h2201}));
    chk("pin_sub", 32'(ref_op(1'b0, 1'b0, 16'h0000, 16'h0001)), 32'({1'b0, 1'b0, 1'b0, 16'hFFFF}));
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags", 32'({bus.zf, bus.cf, bus.ovf}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b1, 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0, "add1");
    run_op(1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, "addwrap");
    run_op(1'b0, 1'b0, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b1, 1'b0, "sub1");
    run_op(1'b0, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, "subneg");
    run_op(1'b0, 1'b1, 16'h0005, 16'h0004, 16'h0000, 1'b1, 1'b1, 1'b0, "subcin");
    run_op(1'b1, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, "addovf");
    run_op(1'b0, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1, "subovf");
    run_op(1'b1, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, "addsmall");
    // Abort in the 2nd RUN cycle; outputs must clear without waiting for a clock
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 1'b1;
    bus.a = 16'hABCD;
    bus.b = 16'h1111;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b1, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, "postrst");
    // start held high with operands changing every cycle
    bus.start = 1'b1;
    for (int i = 0; i < 3 * (NIB + 2) + 1; i++) begin
      bus.op = 1'($urandom);
      bus.cin = 1'($urandom);
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      @(negedge clk);
    end
    for (int i = 0; i < 700; i++) begin
      bus.start = $urandom_range(0, 3) != 0;
      bus.op = 1'($urandom);
      bus.cin = 1'($urandom);
      case ($urandom_range(0, 5))
        0: bus.a = '1;
        1: bus.a = '0;
        2: bus.a = {1'b0, {(W-1){1'b1}}};
        default: bus.a = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: bus.b = '1;
        1: bus.b = '0;
        2: bus.b = {1'b1, {(W-1){1'b0}}};
        default: bus.b = W'($urandom);
      endcase
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (NIB + 3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
